// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: synchronous FIFO with programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a choice of read style.
//
// Parameters
//   DATA_WIDTH  word width in bits
//   ADDR_WIDTH  log2 of capacity; DEPTH = 2**ADDR_WIDTH words
//   FWFT        1 = first-word-fall-through, 0 = registered read on rd_en
//
// Ports
//   clk           sole clock, rising edge
//   rst           asynchronous active-high reset
//   wr_en/wr_data write request and word
//   rd_en         pop (FWFT) or fetch (standard)
//   rd_data       read word
//   af_thresh     almost-full threshold  (1..DEPTH)
//   ae_thresh     almost-empty threshold (0..DEPTH-1)
//   clr_err       clears overflow/underflow
//   full, empty, has_data, almost_full, almost_empty, level
//   overflow, underflow  sticky error flags
module sync_fifo_prog #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned FWFT       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    input  logic                  clr_err,
    output logic                  full,
    output logic                  empty,
    output logic                  has_data,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  wr_acc;
    logic                  rd_acc;
    logic                  mem_pop;
    logic [ADDR_WIDTH:0]   mem_count;

    always_comb begin
        full = (level_q == DEPTH_L);
        // In FWFT mode the output register is what the reader sees, so a word
        // still in the array does not yet make the FIFO non-empty.
        if (FWFT != 0) begin
            empty = !out_valid_q;
        end else begin
            empty = (level_q == '0);
        end
        has_data     = !empty;
        almost_full  = (level_q >= af_thresh);
        almost_empty = (level_q <= ae_thresh);
        level        = level_q;
        rd_data      = data_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

    always_comb begin
        wr_acc    = wr_en && !full;
        rd_acc    = rd_en && !empty;
        // Words held in the array, excluding the FWFT output register.
        mem_count = level_q - (out_valid_q ? ONE_L : '0);

        if (FWFT != 0) begin
            // Refill the output register when it is empty or being popped.
            mem_pop     = (!out_valid_q || rd_acc) && (mem_count != '0);
            out_valid_d = mem_pop ? 1'b1 : (rd_acc ? 1'b0 : out_valid_q);
        end else begin
            mem_pop     = rd_acc;
            out_valid_d = 1'b0;
        end

        data_d   = mem_pop ? mem[rd_ptr_q] : data_q;
        rd_ptr_d = mem_pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;

        unique case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + ONE_L;
            2'b01:   level_d = level_q - ONE_L;
            default: level_d = level_q;
        endcase

        // A fresh error on the clearing edge keeps the flag set.
        overflow_d  = (overflow_q && !clr_err) || (wr_en && full);
        underflow_d = (underflow_q && !clr_err) || (rd_en && empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule
